minitb_ahb_mem_slave: RTL and testbench

//  Synthesizable AHB-lite memory slave that sits directly downstream of the miniTB AHB master BFM.

---
 rtl/minitb_ahb_mem_slave.sv | 160 ++++++++++++++++
 tb/tb_minitb_ahb_mem_slave.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/minitb_ahb_mem_slave.sv
// AHB-lite word-addressed memory slave with programmable per-transfer wait states,
// write-to-read forwarding, out-of-range detection and saturating transfer counters.
module minitb_ahb_mem_slave #(
  parameter int addrWidth = 8,
  parameter int dataWidth = 32,
  parameter int depth     = 256,
  parameter int cntWidth  = 16
) (
  input  logic                 hclk,
  input  logic                 hreset,
  input  logic [1:0]           htrans,
  input  logic [addrWidth-1:0] haddr,
  input  logic                 hwrite,
  input  logic [dataWidth-1:0] hwdata,
  output logic [dataWidth-1:0] hrdata,
  output logic                 hready,
  input  logic [3:0]           wait_cfg,
  output logic                 oob_hit,
  output logic [cntWidth-1:0]  wr_count,
  output logic [cntWidth-1:0]  rd_count
);

  localparam int                 IdxW   = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [addrWidth:0] DepthW = (addrWidth + 1)'(depth);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic in_range(input logic [addrWidth-1:0] a);
    return ({1'b0, a} < DepthW);
  endfunction

  function automatic logic [IdxW-1:0] to_idx(input logic [addrWidth-1:0] a);
    return a[IdxW-1:0];
  endfunction

  logic [dataWidth-1:0] mem_q [depth];

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [addrWidth-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic                 hready_q, hready_d;
  logic [dataWidth-1:0] hrdata_q, hrdata_d;
  logic                 oob_q, oob_d;
  logic [cntWidth-1:0]  wr_cnt_q, wr_cnt_d;
  logic [cntWidth-1:0]  rd_cnt_q, rd_cnt_d;

  logic accept_s;
  logic end_s;
  logic commit_s;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    accept_s = hready_q && (htrans == 2'b10);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          addr_d  = haddr;
          write_d = hwrite;
          if (wait_cfg == 4'd0) begin
            state_d = ST_DONE;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = wait_cfg - 4'd1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A read entering DONE on the edge that commits a write to the same word takes hwdata.
  always_comb begin
    end_s    = (state_q == ST_DONE);
    commit_s = end_s && write_q && in_range(addr_q);
    hready_d = (state_d != ST_WAIT);
    oob_d    = end_s && !in_range(addr_q);
    hrdata_d = hrdata_q;
    if ((state_d == ST_DONE) && !write_d) begin
      if (!in_range(addr_d)) begin
        hrdata_d = {dataWidth{1'b0}};
      end else if (commit_s && (addr_q == addr_d)) begin
        hrdata_d = hwdata;
      end else begin
        hrdata_d = mem_q[to_idx(addr_d)];
      end
    end else begin
      hrdata_d = hrdata_q;
    end
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (end_s && write_q && (wr_cnt_q != {cntWidth{1'b1}})) begin
      wr_cnt_d = wr_cnt_q + {{(cntWidth-1){1'b0}}, 1'b1};
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (end_s && !write_q && (rd_cnt_q != {cntWidth{1'b1}})) begin
      rd_cnt_d = rd_cnt_q + {{(cntWidth-1){1'b0}}, 1'b1};
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= {addrWidth{1'b0}};
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hrdata_q <= {dataWidth{1'b0}};
      oob_q    <= 1'b0;
      wr_cnt_q <= {cntWidth{1'b0}};
      rd_cnt_q <= {cntWidth{1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      hready_q <= hready_d;
      hrdata_q <= hrdata_d;
      oob_q    <= oob_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Storage is deliberately not cleared by reset.
  always_ff @(posedge hclk) begin
    if (!hreset && commit_s) begin
      mem_q[to_idx(addr_q)] <= hwdata;
    end
  end

  assign hready   = hready_q;
  assign hrdata   = hrdata_q;
  assign oob_hit  = oob_q;
  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;

endmodule

// File: tb/tb_minitb_ahb_mem_slave.sv
// Randomised scoreboard bench for minitb_ahb_mem_slave: a pipelined master drives the bus,
// a word-array model predicts each completion, and a bus monitor checks completions in order.
module tb_minitb_ahb_mem_slave;
  localparam int DEPTH = 128;
  localparam int CW    = 4;
  localparam int MAXC  = (1 << CW) - 1;

  logic          hclk;
  logic          hreset;
  logic [1:0]    htrans;
  logic [7:0]    haddr;
  logic          hwrite;
  logic [31:0]   hwdata;
  logic [31:0]   hrdata;
  logic          hready;
  logic [3:0]    wait_cfg;
  logic          oob_hit;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;

  minitb_ahb_mem_slave #(
    .addrWidth(8), .dataWidth(32), .depth(DEPTH), .cntWidth(CW)
  ) dut (
    .hclk(hclk), .hreset(hreset), .htrans(htrans), .haddr(haddr), .hwrite(hwrite),
    .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .wait_cfg(wait_cfg),
    .oob_hit(oob_hit), .wr_count(wr_count), .rd_count(rd_count)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    bit          oob;
    int          n;
    int          wr;
    int          rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [DEPTH];
  int          exp_wr;
  int          exp_rd;
  int          errors;
  int          checks;

  bit   dp_active;
  bit   pend;
  exp_t pend_e;
  int   low_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Track whether a data phase is open, using pre-edge bus values.
  always @(posedge hclk) begin
    if (hreset) begin
      dp_active = 1'b0;
    end else begin
      if (dp_active && hready) dp_active = 1'b0;
      if (hready && htrans == 2'b10) dp_active = 1'b1;
    end
  end

  // Compare each completion against the oldest prediction.
  always @(negedge hclk) begin
    exp_t e;
    if (pend) begin
      check("oob_hit", 32'(oob_hit), 32'(pend_e.oob));
      check("wr_count", 32'(wr_count), 32'(pend_e.wr));
      check("rd_count", 32'(rd_count), 32'(pend_e.rd));
      pend = 1'b0;
    end else if (!hreset) begin
      check("oob_idle", 32'(oob_hit), 32'd0);
    end
    if (!dp_active) begin
      low_cnt = 0;
    end else if (!hready) begin
      low_cnt++;
    end else begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got completion expected none at %0t", $time);
      end else begin
        e = sb.pop_front();
        check("wait_states", 32'(low_cnt), 32'(e.n));
        if (e.is_rd) check("hrdata", hrdata, e.data);
        pend_e = e;
        pend   = 1'b1;
      end
      low_cnt = 0;
    end
  end

  // Present one address phase (called at a negedge) and return after it is accepted.
  task automatic issue(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [3:0] n);
    exp_t e;
    int   guard;
    int   ai;
    htrans   = 2'b10;
    haddr    = a;
    hwrite   = wr;
    wait_cfg = n;
    guard    = 0;
    while (hready !== 1'b1 && guard < 50) begin
      @(negedge hclk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got hready low expected accept within 50 cycles");
    end
    @(negedge hclk);
    if (wr) hwdata = d;
    htrans = 2'b00;
    ai     = int'(a);
    e.is_rd = !wr;
    e.oob   = (ai >= DEPTH);
    e.n     = int'(n);
    e.data  = 32'd0;
    if (wr) begin
      if (!e.oob) mem_m[ai] = d;
      exp_wr = (exp_wr == MAXC) ? MAXC : exp_wr + 1;
    end else begin
      e.data = e.oob ? 32'd0 : mem_m[ai];
      exp_rd = (exp_rd == MAXC) ? MAXC : exp_rd + 1;
    end
    e.wr = exp_wr;
    e.rd = exp_rd;
    sb.push_back(e);
  endtask

  task automatic drain();
    int g;
    htrans = 2'b00;
    g = 0;
    while ((sb.size() != 0 || dp_active) && g < 100) begin
      @(negedge hclk);
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
    end
    repeat (2) @(negedge hclk);
  endtask

  task automatic do_reset();
    htrans = 2'b00;
    hreset = 1'b1;
    sb.delete();
    @(negedge hclk);
    hreset = 1'b0;
    exp_wr = 0;
    exp_rd = 0;
    check("rst_hready", 32'(hready), 32'd1);
    check("rst_hrdata", hrdata, 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);
    check("rst_oob_hit", 32'(oob_hit), 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0; exp_wr = 0; exp_rd = 0;
    dp_active = 1'b0; pend = 1'b0; low_cnt = 0;
    hreset = 1'b1; htrans = 2'b00; haddr = 8'd0; hwrite = 1'b0;
    hwdata = 32'd0; wait_cfg = 4'd0;
    @(negedge hclk);
    do_reset();
    repeat (2) @(negedge hclk);
    check("idle_hready", 32'(hready), 32'd1);
    check("idle_hrdata", hrdata, 32'd0);

    // Preload every implemented word; also drives both counters into saturation.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 8'(i), $urandom, 4'd0);
    for (int i = 0; i < MAXC + 2; i++) issue(1'b0, 8'($urandom_range(0, DEPTH - 1)), 32'd0, 4'd0);
    drain();
    check("sat_wr_count", 32'(wr_count), 32'(MAXC));
    check("sat_rd_count", 32'(rd_count), 32'(MAXC));

    // Memory survives reset.
    issue(1'b1, 8'd3, 32'hA5A5_0001, 4'd0);
    drain();
    do_reset();
    issue(1'b0, 8'd3, 32'd0, 4'd0);
    drain();

    // Back-to-back write then read of the same word.
    do_reset();
    issue(1'b1, 8'h10, 32'h1234_5678, 4'd0);
    issue(1'b0, 8'h10, 32'd0, 4'd0);
    drain();
    check("b2b_wr_count", 32'(wr_count), 32'd1);
    check("b2b_rd_count", 32'(rd_count), 32'd1);

    issue(1'b0, 8'h10, 32'd0, 4'd3);
    drain();

    // Out-of-range write must not alias onto the low half.
    issue(1'b1, 8'hC0, 32'hDEAD_BEEF, 4'd0);
    issue(1'b0, 8'hC0, 32'd0, 4'd0);
    issue(1'b0, 8'h40, 32'd0, 4'd0);
    drain();

    // Reset in the middle of a stalled write discards it.
    htrans = 2'b10; haddr = 8'h20; hwrite = 1'b1; wait_cfg = 4'd5;
    @(negedge hclk);
    hwdata = 32'hCAFE_F00D;
    htrans = 2'b00;
    check("stall_hready", 32'(hready), 32'd0);
    @(negedge hclk);
    do_reset();
    issue(1'b0, 8'h20, 32'd0, 4'd0);
    drain();
    check("abort_wr_count", 32'(wr_count), 32'd0);

    // Write counter saturation.
    do_reset();
    for (int i = 0; i < MAXC + 2; i++) issue(1'b1, 8'($urandom_range(0, DEPTH - 1)), $urandom, 4'd0);
    drain();
    check("sat2_wr_count", 32'(wr_count), 32'(MAXC));

    // Random mixed traffic with wait states, gaps and out-of-range addresses.
    do_reset();
    for (int i = 0; i < 120; i++) begin
      logic [7:0] a;
      if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(DEPTH, 255));
      else a = 8'($urandom_range(0, 15));
      issue(1'($urandom_range(0, 1)), a, $urandom,
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 4)));
      if ($urandom_range(0, 3) == 0) begin
        htrans = 2'b00;
        @(negedge hclk);
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
